// File: rtl/ir_pipeline_chain_pkg.sv
// Shared definitions for the instruction-register pipeline: field positions,
// the bubble encoding and the per-edge pipeline action.
package ir_pipeline_chain_pkg;

  // Default instruction field positions: 2-bit RA (dest/src1) and RB (src2).
  localparam int RA_LSB_DEF = 6;
  localparam int RB_LSB_DEF = 4;

  // Content loaded into a stage that holds no instruction.
  localparam logic [7:0] BUBBLE_INSTR = 8'h00;

  // What the pipeline does on the next clock edge, in priority order
  // hold > flush > hazard > advance (reset handled in the registers).
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_HAZARD  = 2'd1,
    ACT_FLUSH   = 2'd2,
    ACT_HOLD    = 2'd3
  } pipe_act_e;

endpackage

// File: rtl/ir_pipeline_chain_if.sv
// Fetch port between the instruction memory and the IR pipeline.
// Handshake: fetch_instr is transferred on a rising edge when
// fetch_valid & fetch_ready are both high; fetch_ready may drop because of
// hold, flush or a RAW stall, and the fetch side keeps the same instruction
// (and its PC) until it is accepted.
interface ir_pipeline_chain_if #(
  parameter int IW = 8
);
  logic          fetch_valid;
  logic [IW-1:0] fetch_instr;
  logic          fetch_ready;

  modport master (
    output fetch_valid,
    output fetch_instr,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_instr,
    output fetch_ready
  );
endinterface

// File: rtl/ir_pipe_stage.sv
// One pipeline stage register: {valid, instr} with sync reset, load and kill.
// Kill forces a bubble and wins over load.
module ir_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Stage register: reset/kill give an all-zero bubble, load takes upstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (kill) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ir_pipeline_chain.sv
// Parametrised instruction-register pipeline (stage 1 = fetch, stage DEPTH =
// writeback) with global hold, branch flush, RAW-hazard stall with bubble
// insertion, and saturating retire/bubble counters.
module ir_pipeline_chain
  import ir_pipeline_chain_pkg::*;
#(
  parameter int IW        = 8,
  parameter int DEPTH     = 4,
  parameter int HAZ_STAGE = 2,
  parameter int FLUSH_N   = 2,
  parameter int RA_LSB    = RA_LSB_DEF,
  parameter int RB_LSB    = RB_LSB_DEF,
  parameter bit RF_WT     = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  ir_pipeline_chain_if.slave    fetch,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [DEPTH-1:0]      stage_writes,
  input  logic                  uses_ra,
  input  logic                  uses_rb,
  input  logic                  count_en,
  output logic [DEPTH*IW-1:0]   stage_instr,
  output logic [DEPTH-1:0]      stage_valid,
  output logic                  hazard,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  // With write-through the RF forwards the writeback value, so the last
  // stage does not need to be compared.
  localparam int LAST_CMP = RF_WT ? DEPTH - 1 : DEPTH;

  pipe_act_e        act;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] kill;
  logic [IW:0]      stage_d [DEPTH];
  logic [IW:0]      stage_q [DEPTH];
  logic [1:0]       ra_h;
  logic [1:0]       rb_h;
  logic             match_ra;
  logic             match_rb;

  // Writers younger than or at the hazard stage never matter to the compare.
  logic unused_writes;
  assign unused_writes = ^stage_writes[HAZ_STAGE-1:0];

  // Stage registers; stage k lives at index k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Non-instructions enter as a clean bubble so bubble content stays 0.
      assign stage_d[k] = fetch.fetch_valid ? {1'b1, fetch.fetch_instr}
                                            : {1'b0, BUBBLE_INSTR[IW-1:0]};
    end else begin : g_rest
      assign stage_d[k] = stage_q[k-1];
    end

    ir_pipe_stage #(.W(IW + 1)) u_stage (
      .clock (clock),
      .reset (reset),
      .load  (load[k]),
      .kill  (kill[k]),
      .d     (stage_d[k]),
      .q     (stage_q[k])
    );

    assign stage_valid[k]               = stage_q[k][IW];
    assign stage_instr[k*IW +: IW]      = stage_q[k][IW-1:0];
  end

  // RAW compare: source fields of the hazard stage against older writers' RA.
  always_comb begin
    ra_h     = stage_instr[(HAZ_STAGE-1)*IW + RA_LSB +: 2];
    rb_h     = stage_instr[(HAZ_STAGE-1)*IW + RB_LSB +: 2];
    match_ra = 1'b0;
    match_rb = 1'b0;
    for (int j = HAZ_STAGE + 1; j <= LAST_CMP; j++) begin
      if (stage_valid[j-1] && stage_writes[j-1]) begin
        if (stage_instr[(j-1)*IW + RA_LSB +: 2] == ra_h) match_ra = 1'b1;
        if (stage_instr[(j-1)*IW + RA_LSB +: 2] == rb_h) match_rb = 1'b1;
      end
    end
    hazard = stage_valid[HAZ_STAGE-1] &
             ((uses_ra & match_ra) | (uses_rb & match_rb));
  end

  // Pick this edge's action and turn it into per-stage load/kill controls.
  always_comb begin
    act  = ACT_ADVANCE;
    load = '0;
    kill = '0;
    if (hold)        act = ACT_HOLD;
    else if (flush)  act = ACT_FLUSH;
    else if (hazard) act = ACT_HAZARD;

    case (act)
      ACT_HOLD: begin
        load = '0;
      end
      ACT_FLUSH: begin
        // Killing FLUSH_N+1 too stops the last killed instr moving into it.
        load = '1;
        for (int k = 0; k < DEPTH; k++) kill[k] = (k <= FLUSH_N);
      end
      ACT_HAZARD: begin
        // Stages 1..H freeze, H+1 gets a bubble, older stages drain.
        for (int k = 0; k < DEPTH; k++) load[k] = (k > HAZ_STAGE);
        kill[HAZ_STAGE] = 1'b1;
      end
      default: begin
        load = '1;
      end
    endcase
  end

  assign fetch.fetch_ready = ~reset & (act == ACT_ADVANCE);

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else if (act != ACT_HOLD && count_en) begin
      if (stage_valid[DEPTH-1] && retire_cnt != '1) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
      if (act == ACT_HAZARD && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_pipeline_chain.sv
// Directed bench for ir_pipeline_chain (IW=8, DEPTH=4, H=2, FLUSH_N=2,
// RF_WT=0, CNT_W=4 so counter saturation is reachable).
module tb_ir_pipeline_chain;

  logic        clock;
  logic        reset;
  logic        hold;
  logic        flush;
  logic [3:0]  stage_writes;
  logic        uses_ra;
  logic        uses_rb;
  logic        count_en;
  logic [31:0] stage_instr;
  logic [3:0]  stage_valid;
  logic        hazard;
  logic [3:0]  retire_cnt;
  logic [3:0]  bubble_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ir_pipeline_chain_if #(.IW(8)) fif ();

  ir_pipeline_chain #(
    .IW(8), .DEPTH(4), .HAZ_STAGE(2), .FLUSH_N(2),
    .RA_LSB(6), .RB_LSB(4), .RF_WT(1'b0), .CNT_W(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fetch        (fif),
    .hold         (hold),
    .flush        (flush),
    .stage_writes (stage_writes),
    .uses_ra      (uses_ra),
    .uses_rb      (uses_rb),
    .count_en     (count_en),
    .stage_instr  (stage_instr),
    .stage_valid  (stage_valid),
    .hazard       (hazard),
    .retire_cnt   (retire_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 2ns after it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic [7:0] ins);
    fif.fetch_valid = 1'b1;
    fif.fetch_instr = ins;
    tick();
  endtask

  task automatic check_pipe(input string tag, input logic [31:0] ins,
                            input logic [3:0] vld, input logic [3:0] ret,
                            input logic [3:0] bub);
    check_val({tag, "_instr"},  stage_instr, ins);
    check_val({tag, "_valid"},  {28'd0, stage_valid}, {28'd0, vld});
    check_val({tag, "_retire"}, {28'd0, retire_cnt},  {28'd0, ret});
    check_val({tag, "_bubble"}, {28'd0, bubble_cnt},  {28'd0, bub});
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; flush = 1'b0; stage_writes = 4'b0000;
    uses_ra = 1'b0; uses_rb = 1'b0; count_en = 1'b1;
    fif.fetch_valid = 1'b1; fif.fetch_instr = 8'h5A;

    // Reset state
    tick(); tick();
    check_pipe("reset", 32'h0, 4'h0, 4'd0, 4'd0);
    check_val("reset_ready", {31'd0, fif.fetch_ready}, 32'd0);

    // Basic stream: 0x11 reaches stage 4 after 4 edges, retires on the 5th
    reset = 1'b0;
    begin
      logic [7:0] seq [4];
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
        fif.fetch_instr = seq[i];
        #1 check_val("stream_ready", {31'd0, fif.fetch_ready}, 32'd1);
        push(seq[i]);
      end
    end
    check_pipe("stream4", 32'h11223344, 4'hF, 4'd0, 4'd0);
    push(8'h55);
    check_pipe("stream5", 32'h22334455, 4'hF, 4'd1, 4'd0);

    // Set up writer 0x40 (RA=1) in stage 3 and reader 0x50 in stage 2
    push(8'h40); push(8'h50); push(8'h66);
    check_pipe("haz_setup", 32'h55405066, 4'hF, 4'd4, 4'd0);
    stage_writes = 4'b0100; uses_ra = 1'b1; fif.fetch_instr = 8'h77;
    #1;
    check_val("haz_on", {31'd0, hazard}, 32'd1);
    check_val("haz_ready", {31'd0, fif.fetch_ready}, 32'd0);
    tick();
    check_pipe("haz_b1", 32'h40005066, 4'b1011, 4'd5, 4'd1);
    stage_writes = 4'b1000;
    #1 check_val("haz_wb", {31'd0, hazard}, 32'd1);
    tick();
    check_pipe("haz_b2", 32'h00005066, 4'b0011, 4'd6, 4'd2);
    stage_writes = 4'b0000; uses_ra = 1'b0;
    #1;
    check_val("haz_off", {31'd0, hazard}, 32'd0);
    check_val("haz_off_ready", {31'd0, fif.fetch_ready}, 32'd1);
    push(8'h77);
    check_pipe("resume1", 32'h00506677, 4'b0111, 4'd6, 4'd2);
    push(8'h88);
    check_pipe("resume2", 32'h50667788, 4'hF, 4'd6, 4'd2);

    // Flush with a simultaneous hazard (0x66 writes RA=1, 0x77 reads RA=1)
    flush = 1'b1; stage_writes = 4'b0100; uses_ra = 1'b1;
    fif.fetch_instr = 8'h99;
    #1;
    check_val("flush_haz", {31'd0, hazard}, 32'd1);
    check_val("flush_ready", {31'd0, fif.fetch_ready}, 32'd0);
    tick();
    check_pipe("flush", 32'h66000000, 4'b1000, 4'd7, 4'd2);
    flush = 1'b0; stage_writes = 4'b0000; uses_ra = 1'b0;

    // Refill, then hold for 3 cycles with flush pulsed
    push(8'hA1);
    check_pipe("refill1", 32'h000000A1, 4'b0001, 4'd8, 4'd2);
    push(8'hA2); push(8'hA3); push(8'hA4);
    check_pipe("refill4", 32'hA1A2A3A4, 4'hF, 4'd8, 4'd2);
    hold = 1'b1; flush = 1'b1; fif.fetch_instr = 8'hA5;
    #1 check_val("hold_ready", {31'd0, fif.fetch_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pipe("hold", 32'hA1A2A3A4, 4'hF, 4'd8, 4'd2);
    end
    hold = 1'b0; flush = 1'b0;
    push(8'hA5);
    check_pipe("unhold", 32'hA2A3A4A5, 4'hF, 4'd9, 4'd2);

    // Saturation: 9 + 10 retirements clamps at 0xF
    for (int i = 0; i < 10; i++) begin
      push(8'hB0 + 8'(i));
      if (i == 5) check_val("sat_reach", {28'd0, retire_cnt}, 32'd15);
    end
    check_val("sat_hold", {28'd0, retire_cnt}, 32'd15);

    // Reset mid-stream
    reset = 1'b1;
    #1 check_val("rst_ready", {31'd0, fif.fetch_ready}, 32'd0);
    tick();
    check_pipe("midreset", 32'h0, 4'h0, 4'd0, 4'd0);

    // count_en=0 blocks retire increments
    reset = 1'b0; count_en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    check_pipe("cnt_off", 32'hC2C3C4C5, 4'hF, 4'd0, 4'd0);
    count_en = 1'b1;
    push(8'hC6);
    check_pipe("cnt_on", 32'hC3C4C5C6, 4'hF, 4'd1, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
